// File: rtl/rx_stream_packetizer.sv
// Streams one 1032-byte "from radio" UDP payload per grant from the RX I/Q FIFO.
// Optional RXSTREAM_SEQ_CLEAR_EN: clear the sequence counter while idle with run low.
module rx_stream_packetizer #(
  parameter int SAMPLES_PER_FRAME = 63,
  parameter int START_THRESHOLD   = 126,
  parameter int PAYLOAD_LEN       = 1032
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        have_ip,
  input  logic        udp_tx_enable,
  output logic        udp_tx_request,
  output logic [7:0]  udp_tx_data,
  output logic [10:0] udp_tx_length,
  input  logic [47:0] rx_data,
  output logic        rx_request,
  input  logic [10:0] rx_length
);

  localparam int          FRAME_LEN = 8 + 8 * SAMPLES_PER_FRAME;
  localparam logic [10:0] LAST      = 11'(PAYLOAD_LEN - 1);

  typedef enum logic [1:0] {IDLE, REQUEST, SEND} state_e;

  state_e      state_q;
  logic [10:0] cnt_q;
  logic [31:0] seq_q;
  logic [39:0] hold_q;
  logic        req_q, rxreq_q;
  logic [7:0]  data_q;

  logic [10:0] nxt, off;
  logic [7:0]  data_d;
  logic        rxreq_d, first_d, start_d;

  // Offset of byte k inside its 512-byte frame (only meaningful for k >= 8).
  function automatic logic [10:0] frame_off(input logic [10:0] k);
    logic [10:0] m;
    m = k - 11'd8;
    return (m >= 11'(FRAME_LEN)) ? m - 11'(FRAME_LEN) : m;
  endfunction

  function automatic logic sample_start(input logic [10:0] k);
    logic [10:0] o;
    o = frame_off(k);
    return (k >= 11'd8) && (k < 11'(PAYLOAD_LEN)) && (o >= 11'd8) && (o[2:0] == 3'd0);
  endfunction

  assign nxt     = cnt_q + 11'd1;
  assign off     = frame_off(nxt);
  assign start_d = run && have_ip && (rx_length >= 11'(START_THRESHOLD));

  always_comb begin
    data_d  = 8'h00;
    first_d = sample_start(nxt);
    rxreq_d = sample_start(nxt + 11'd2);
    if (nxt < 11'd8) begin
      case (nxt[2:0])
        3'd0:    data_d = 8'hEF;
        3'd1:    data_d = 8'hFE;
        3'd2:    data_d = 8'h01;
        3'd3:    data_d = 8'h06;
        3'd4:    data_d = seq_q[31:24];
        3'd5:    data_d = seq_q[23:16];
        3'd6:    data_d = seq_q[15:8];
        default: data_d = seq_q[7:0];
      endcase
    end else if (off < 11'd3) begin
      data_d = 8'h7F;
    end else if (off >= 11'd8) begin
      // The first byte of a sample comes straight off the FIFO; the rest from the hold register.
      case (off[2:0])
        3'd0:    data_d = rx_data[47:40];
        3'd1:    data_d = hold_q[39:32];
        3'd2:    data_d = hold_q[31:24];
        3'd3:    data_d = hold_q[23:16];
        3'd4:    data_d = hold_q[15:8];
        3'd5:    data_d = hold_q[7:0];
        default: data_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seq_q   <= '0;
      hold_q  <= '0;
      req_q   <= 1'b0;
      rxreq_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          rxreq_q <= 1'b0;
          if (start_d) begin
            state_q <= REQUEST;
            req_q   <= 1'b1;
          end
`ifdef RXSTREAM_SEQ_CLEAR_EN
          if (!run) seq_q <= '0;
`endif
        end
        REQUEST: begin
          if (udp_tx_enable) begin
            state_q <= SEND;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            data_q  <= 8'hEF;
          end
        end
        SEND: begin
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            seq_q   <= seq_q + 32'd1;
            data_q  <= 8'h00;
            rxreq_q <= 1'b0;
          end else begin
            cnt_q   <= nxt;
            data_q  <= data_d;
            rxreq_q <= rxreq_d;
            if (first_d) hold_q <= rx_data[39:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign udp_tx_request = req_q;
  assign udp_tx_data    = data_q;
  assign udp_tx_length  = 11'(PAYLOAD_LEN);
  assign rx_request     = rxreq_q;

endmodule

// File: tb/tb_rx_stream_packetizer.sv
// Directed-sequence bench for rx_stream_packetizer with a queue-style FIFO and payload model.
module tb_rx_stream_packetizer;
  localparam int NSMP = 126 * 12;

  logic        clk = 1'b0;
  logic        reset_n, run, have_ip, udp_tx_enable;
  logic        udp_tx_request;
  logic [7:0]  udp_tx_data;
  logic [10:0] udp_tx_length;
  logic [47:0] rx_data;
  logic        rx_request;
  logic [10:0] rx_length;

  int          checks = 0;
  int          failures = 0;
  int          rd_cnt = 0;
  logic [47:0] smp  [0:NSMP-1];
  logic [7:0]  got  [0:1031];
  logic [7:0]  expb [0:1031];
  logic [31:0] exp_seq;

  always #5 clk = ~clk;

  rx_stream_packetizer dut (
    .clk(clk), .reset_n(reset_n), .run(run), .have_ip(have_ip),
    .udp_tx_enable(udp_tx_enable), .udp_tx_request(udp_tx_request),
    .udp_tx_data(udp_tx_data), .udp_tx_length(udp_tx_length),
    .rx_data(rx_data), .rx_request(rx_request), .rx_length(rx_length)
  );

  // FIFO with one cycle of read latency: a strobe seen at an edge presents the next word.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_data <= '0;
    else if (rx_request) begin
      rx_data <= smp[rd_cnt % NSMP];
      rd_cnt  <= rd_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] pack(input int start, input int n);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[119:0], got[start + i]};
    return r;
  endfunction

  task automatic build_exp(input int base, input logic [31:0] s);
    int p;
    logic [47:0] w;
    expb[0] = 8'hEF; expb[1] = 8'hFE; expb[2] = 8'h01; expb[3] = 8'h06;
    expb[4] = s[31:24]; expb[5] = s[23:16]; expb[6] = s[15:8]; expb[7] = s[7:0];
    p = 8;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 3; i++) begin expb[p] = 8'h7F; p++; end
      for (int i = 0; i < 5; i++) begin expb[p] = 8'h00; p++; end
      for (int i = 0; i < 63; i++) begin
        w = smp[(base + f * 63 + i) % NSMP];
        for (int b = 0; b < 6; b++) begin expb[p] = w[47 - 8 * b -: 8]; p++; end
        expb[p] = 8'h00; p++;
        expb[p] = 8'h00; p++;
      end
    end
  endtask

  task automatic wait_req(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (udp_tx_request === 1'b1) begin seen = 1'b1; break; end
    end
    chk(tag, 128'(seen), 128'(1));
  endtask

  // kind: 0 plain, 1 drop run at byte 'at', 2 reset at byte 'at', 3 stray grant at byte 'at'
  task automatic packet(input int kind, input int at);
    int base, bad, lenbad;
    base = rd_cnt;
    build_exp(base, exp_seq);
    udp_tx_enable = 1'b1;
    @(negedge clk);
    udp_tx_enable = 1'b0;
    chk("req_drop", 128'(udp_tx_request), 128'(0));
    bad = 0; lenbad = 0;
    for (int k = 0; k < 1032; k++) begin
      if (k > 0) @(negedge clk);
      got[k] = udp_tx_data;
      if (udp_tx_data !== expb[k]) bad++;
      if (udp_tx_length !== 11'd1032) lenbad++;
      if (kind == 1 && k == at) run = 1'b0;
      if (kind == 3 && k == at) udp_tx_enable = 1'b1;
      if (kind == 3 && k == at + 1) udp_tx_enable = 1'b0;
      if (kind == 2 && k == at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_req", 128'(udp_tx_request), 128'(0));
        chk("rst_rxreq", 128'(rx_request), 128'(0));
        chk("rst_data", 128'(udp_tx_data), 128'(0));
        chk("partial_payload", 128'(bad), 128'(0));
        return;
      end
    end
    chk("payload_bad_bytes", 128'(bad), 128'(0));
    chk("length_bad_cycles", 128'(lenbad), 128'(0));
    chk("rx_reads", 128'(rd_cnt - base), 128'(126));
    exp_seq = exp_seq + 32'd1;
  endtask

  initial begin
    logic [63:0] r;
    int cnt, rd0;
    for (int i = 0; i < NSMP; i++) begin
      if (i < 126) smp[i] = (i % 2 == 1) ? 48'h161514131211 : 48'hAFAEADACABAA;
      else begin r = {$urandom(), $urandom()}; smp[i] = r[47:0]; end
    end
    reset_n = 1'b0; run = 1'b0; have_ip = 1'b0; udp_tx_enable = 1'b0; rx_length = '0;
    exp_seq = '0;
    repeat (3) @(negedge clk);
    chk("reset_req", 128'(udp_tx_request), 128'(0));
    chk("reset_rxreq", 128'(rx_request), 128'(0));
    chk("reset_data", 128'(udp_tx_data), 128'(0));
    chk("reset_len", 128'(udp_tx_length), 128'(1032));

    reset_n = 1'b1;
    @(negedge clk);
    run = 1'b1; have_ip = 1'b1; rx_length = 11'd17;
    repeat (20) @(negedge clk);
    chk("low_fill_no_req", 128'(udp_tx_request), 128'(0));
    chk("low_fill_no_read", 128'(rd_cnt), 128'(0));
    rx_length = 11'd125;
    repeat (10) @(negedge clk);
    chk("fill125_no_req", 128'(udp_tx_request), 128'(0));
    rx_length = 11'd126;
    wait_req(2, "req_at_threshold");
    repeat (3) @(negedge clk);
    chk("req_held", 128'(udp_tx_request), 128'(1));
    rx_length = 11'd172;

    packet(0, 0);
    chk("hdr_bytes_0_15", pack(0, 16), 128'hEFFE0106_00000000_7F7F7F00_00000000);
    chk("bytes_16_23", pack(16, 8), 128'hAFAEADACABAA0000);
    chk("bytes_24_29", pack(24, 6), 128'h161514131211);

    @(negedge clk);
    chk("b2b_idle_gap", 128'(udp_tx_request), 128'(0));
    @(negedge clk);
    chk("b2b_rereq", 128'(udp_tx_request), 128'(1));
    packet(0, 0);
    chk("seq_bytes_pkt1", pack(4, 4), 128'h00000001);
    chk("frame2_sync", pack(519, 5), 128'h007F7F7F00);

    run = 1'b0;
    rd0 = rd_cnt;
    repeat (3) @(negedge clk);
    udp_tx_enable = 1'b1;
    @(negedge clk);
    udp_tx_enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_grant_ignored", 128'(udp_tx_request), 128'(0));
    chk("idle_no_read", 128'(rd_cnt - rd0), 128'(0));
`ifdef RXSTREAM_SEQ_CLEAR_EN
    exp_seq = '0;
`endif

    run = 1'b1;
    wait_req(3, "req_resume");
    packet(3, 100);

    wait_req(3, "req_pkt3");
    packet(1, 400);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (udp_tx_request !== 1'b0) cnt++;
    end
    chk("no_req_after_run_drop", 128'(cnt), 128'(0));
`ifdef RXSTREAM_SEQ_CLEAR_EN
    exp_seq = '0;
`endif

    run = 1'b1;
    wait_req(3, "req_pkt4");
    have_ip = 1'b0;
    repeat (4) @(negedge clk);
    chk("req_hold_ip_drop", 128'(udp_tx_request), 128'(1));
    packet(0, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (udp_tx_request !== 1'b0) cnt++;
    end
    chk("no_req_without_ip", 128'(cnt), 128'(0));
    have_ip = 1'b1;

    wait_req(3, "req_pkt5");
    packet(2, 300);
    exp_seq = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_req(3, "req_after_reset");
    packet(0, 0);
    chk("seq_after_reset", pack(4, 4), 128'h00000000);

    run = 1'b0;
    repeat (4) @(negedge clk);
    run = 1'b1;
`ifdef RXSTREAM_SEQ_CLEAR_EN
    exp_seq = '0;
`endif
    wait_req(3, "req_after_run_toggle");
    packet(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
